// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: mode encodings and widths.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ZERO   = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SIGN   = 2'b01;
  localparam logic [MODE_W-1:0] MODE_HIGH   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_PREFIX = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/imm_extender_if.sv
// Chunk-in / result-out handshake bundle for imm_extender.
// master: producer of chunks and consumer of results; slave: the extender.
interface imm_extender_if
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic [MODE_W-1:0] mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_ovf;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational extension datapath: joins the k accumulated prefix chunks
// with the incoming chunk into V (width (k+1)*IN_W) and zero-extends,
// sign-extends or high-places it into OUT_W bits.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int ACC_W = 8,
  parameter int KW    = 1
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [KW-1:0]     k,
  input  logic [IN_W-1:0]   in_data,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  result
);
  localparam int CHUNKS = OUT_W / IN_W;

  logic [OUT_W-1:0] full;
  logic [31:0]      w;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] top;
  logic [OUT_W-1:0] v;
  logic             sign_bit;

  generate
    if (CHUNKS > 1) begin : g_multi
      assign full = {acc, in_data};
    end else begin : g_single
      logic unused_acc;
      assign unused_acc = ^acc;
      assign full = in_data;
    end
  endgenerate

  // Build V and select the extension; mask marks the live low W bits.
  always_comb begin
    w        = (32'(k) + 32'd1) * 32'(IN_W);
    mask     = {OUT_W{1'b1}} >> (32'(OUT_W) - w);
    top      = mask & ~(mask >> 1);
    v        = full & mask;
    sign_bit = |(full & top);
    case (mode)
      MODE_ZERO: result = v;
      MODE_SIGN: begin
        if (sign_bit) begin
          result = v | ~mask;
        end else begin
          result = v;
        end
      end
      MODE_HIGH: result = v << (32'(OUT_W) - w);
      default:   result = v;
    endcase
  end
endmodule

// File: rtl/imm_extender.sv
// Registered immediate extender with prefix accumulation and a one-deep
// valid/ready output register. Optional macro IMM_EXT_FLUSH_EN adds a flush
// input that discards pending prefixes (and any chunk offered that cycle).
module imm_extender
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input logic clk,
  input logic rst,
`ifdef IMM_EXT_FLUSH_EN
  input logic flush,
`endif
  imm_extender_if.slave bus
);
  localparam int CHUNKS = OUT_W / IN_W;
  localparam int ACC_W  = (CHUNKS > 1) ? (CHUNKS - 1) * IN_W : IN_W;
  localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [KW-1:0] K_MAX = KW'(CHUNKS - 1);

  state_t                 state;
  logic [ACC_W-1:0]       acc;
  logic [KW-1:0]          k;
  logic                   ovf_pend;
  logic                   result_valid;
  logic [OUT_W-1:0]       result_data;
  logic                   result_ovf;

  logic                   flush_req;
  logic                   accept;
  logic                   final_take;
  logic [KW-1:0]          k_eff;
  logic [ACC_W+IN_W-1:0]  acc_shift;
  logic [OUT_W-1:0]       ext_value;

`ifdef IMM_EXT_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign bus.in_ready  = !result_valid || bus.out_ready;
  assign bus.out_valid = result_valid;
  assign bus.out_data  = result_data;
  assign bus.out_ovf   = result_ovf;

  assign accept     = bus.in_valid && bus.in_ready;
  assign final_take = accept && !flush_req && (bus.mode != MODE_PREFIX);
  assign k_eff      = (state == ST_ACCUM) ? k : '0;
  assign acc_shift  = {acc, bus.in_data};

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ACC_W (ACC_W),
    .KW    (KW)
  ) u_core (
    .acc     (acc),
    .k       (k_eff),
    .in_data (bus.in_data),
    .mode    (bus.mode),
    .result  (ext_value)
  );

  // Prefix FSM, accumulator and output register; rst beats flush beats accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      acc          <= '0;
      k            <= '0;
      ovf_pend     <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_ovf   <= 1'b0;
    end else begin
      if (final_take) begin
        result_valid <= 1'b1;
        result_data  <= ext_value;
        result_ovf   <= ovf_pend;
      end else if (bus.out_ready) begin
        result_valid <= 1'b0;
      end

      if (flush_req) begin
        state    <= ST_IDLE;
        acc      <= '0;
        k        <= '0;
        ovf_pend <= 1'b0;
      end else if (accept) begin
        case (state)
          ST_IDLE, ST_ACCUM: begin
            if (bus.mode == MODE_PREFIX) begin
              // Oldest chunk falls off the top once the accumulator is full.
              acc   <= acc_shift[ACC_W-1:0];
              state <= ST_ACCUM;
              if (k == K_MAX) begin
                ovf_pend <= 1'b1;
              end else begin
                k <= k + KW'(1);
              end
            end else begin
              state    <= ST_IDLE;
              acc      <= '0;
              k        <= '0;
              ovf_pend <= 1'b0;
            end
          end
          default: begin
            state    <= ST_IDLE;
            acc      <= '0;
            k        <= '0;
            ovf_pend <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imm_extender.sv
// Directed bench for imm_extender: a 8->16 instance (a) and a 8->32
// instance (b). Optional macro IMM_EXT_FLUSH_EN enables the flush case.
module tb_imm_extender;
  import imm_ext_pkg::*;

  logic clk = 1'b0;
  logic rst;
`ifdef IMM_EXT_FLUSH_EN
  logic flush;
`endif

  always #5 clk = ~clk;

  imm_extender_if #(.IN_W(8), .OUT_W(16)) a_if ();
  imm_extender_if #(.IN_W(8), .OUT_W(32)) b_if ();

  imm_extender #(.IN_W(8), .OUT_W(16)) dut_a (
    .clk   (clk),
    .rst   (rst),
`ifdef IMM_EXT_FLUSH_EN
    .flush (flush),
`endif
    .bus   (a_if)
  );

  imm_extender #(.IN_W(8), .OUT_W(32)) dut_b (
    .clk   (clk),
    .rst   (rst),
`ifdef IMM_EXT_FLUSH_EN
    .flush (flush),
`endif
    .bus   (b_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  // Record every result the consumer of instance a actually takes.
  always @(posedge clk) begin
    if (!rst && a_if.out_valid && a_if.out_ready) got_q.push_back(a_if.out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put_a(input logic [1:0] m, input logic [7:0] d);
    a_if.in_valid = 1'b1;
    a_if.mode     = m;
    a_if.in_data  = d;
    @(posedge clk);
    #1;
    a_if.in_valid = 1'b0;
  endtask

  task automatic final_a(input string tag, input logic [1:0] m, input logic [7:0] d,
                         input logic [15:0] exp, input logic ovf);
    put_a(m, d);
    check({tag, "_valid"}, 32'(a_if.out_valid), 32'd1);
    check({tag, "_data"}, 32'(a_if.out_data), 32'(exp));
    check({tag, "_ovf"}, 32'(a_if.out_ovf), 32'(ovf));
    exp_q.push_back(exp);
  endtask

  task automatic put_b(input logic [1:0] m, input logic [7:0] d);
    b_if.in_valid = 1'b1;
    b_if.mode     = m;
    b_if.in_data  = d;
    @(posedge clk);
    #1;
    b_if.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
`ifdef IMM_EXT_FLUSH_EN
    flush = 1'b0;
`endif
    a_if.in_valid = 1'b0; a_if.in_data = 8'h00; a_if.mode = MODE_ZERO; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_data = 8'h00; b_if.mode = MODE_ZERO; b_if.out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_data", 32'(a_if.out_data), 32'd0);
    check("rst_ovf", 32'(a_if.out_ovf), 32'd0);
    check("rst_in_ready", 32'(a_if.in_ready), 32'd1);

    // Single-chunk extensions, one cycle latency each.
    final_a("sign30", MODE_SIGN, 8'h30, 16'h0030, 1'b0);
    final_a("sign80", MODE_SIGN, 8'h80, 16'hFF80, 1'b0);
    final_a("sign50", MODE_SIGN, 8'h50, 16'h0050, 1'b0);
    final_a("zeroC0", MODE_ZERO, 8'hC0, 16'h00C0, 1'b0);
    final_a("high50", MODE_HIGH, 8'h50, 16'h5000, 1'b0);

    // Prefix produces no output, then full-width final.
    put_a(MODE_PREFIX, 8'h12);
    check("prefix_no_out", 32'(a_if.out_valid), 32'd0);
    final_a("pfx_sign", MODE_SIGN, 8'h34, 16'h1234, 1'b0);
    put_a(MODE_PREFIX, 8'hAB);
    final_a("pfx_high", MODE_HIGH, 8'hCD, 16'hABCD, 1'b0);

    // Prefix overflow: oldest chunks dropped, flag on this result only.
    put_a(MODE_PREFIX, 8'h11);
    put_a(MODE_PREFIX, 8'h22);
    put_a(MODE_PREFIX, 8'h33);
    final_a("ovf", MODE_ZERO, 8'h44, 16'h3344, 1'b1);
    final_a("after_ovf", MODE_ZERO, 8'h01, 16'h0001, 1'b0);

    // Backpressure: hold out_ready low with a chunk waiting.
    idle(1);
    check("drained", 32'(a_if.out_valid), 32'd0);
    a_if.out_ready = 1'b0;
    final_a("bp_first", MODE_ZERO, 8'h05, 16'h0005, 1'b0);
    a_if.in_valid = 1'b1; a_if.mode = MODE_ZERO; a_if.in_data = 8'h06;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(a_if.in_ready), 32'd0);
      idle(1);
      check("bp_hold", 32'(a_if.out_data), 32'h0005);
    end
    a_if.out_ready = 1'b1;
    idle(1);
    check("bp_reload_valid", 32'(a_if.out_valid), 32'd1);
    check("bp_reload_data", 32'(a_if.out_data), 32'h0006);
    exp_q.push_back(16'h0006);
    a_if.in_valid = 1'b0;
    final_a("bp_next", MODE_ZERO, 8'h07, 16'h0007, 1'b0);
    idle(1);

    // Reset mid-accumulation discards the prefix.
    put_a(MODE_PREFIX, 8'hAB);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_mid_valid", 32'(a_if.out_valid), 32'd0);
    final_a("rst_mid", MODE_SIGN, 8'h80, 16'hFF80, 1'b0);
    idle(1);

`ifdef IMM_EXT_FLUSH_EN
    // Flush discards the prefix and the final chunk offered alongside it.
    put_a(MODE_PREFIX, 8'hAB);
    flush = 1'b1;
    put_a(MODE_ZERO, 8'h11);
    flush = 1'b0;
    check("flush_discard", 32'(a_if.out_valid), 32'd0);
    final_a("flush_after", MODE_SIGN, 8'h80, 16'hFF80, 1'b0);
    idle(1);
`endif

    // 32-bit instance.
    put_b(MODE_PREFIX, 8'h80);
    put_b(MODE_SIGN, 8'h01);
    check("b_sign16", b_if.out_data, 32'hFFFF8001);
    put_b(MODE_PREFIX, 8'h12);
    put_b(MODE_PREFIX, 8'h34);
    put_b(MODE_PREFIX, 8'h56);
    put_b(MODE_ZERO, 8'h78);
    check("b_full", b_if.out_data, 32'h12345678);
    check("b_full_ovf", 32'(b_if.out_ovf), 32'd0);
    put_b(MODE_PREFIX, 8'hAB);
    put_b(MODE_HIGH, 8'hCD);
    check("b_high", b_if.out_data, 32'hABCD0000);
    put_b(MODE_ZERO, 8'h80);
    check("b_zero", b_if.out_data, 32'h00000080);

    // Every result of instance a delivered once, in order.
    idle(3);
    check("order_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("order_item", 32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
